// File: rtl/mem_lsu.sv
// mem_lsu: byte/half/word load-store initiator for the single-cycle memory port.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned/illegal requests instead of forcing alignment.
module mem_lsu (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  output logic [31:0] mem_raddr,
  output logic        mem_wen,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  logic [1:0]  state_reg, state_next;
  logic        wen_reg, unsigned_reg;
  logic [31:0] addr_reg, wdata_reg, rdata_reg;
  logic [1:0]  size_reg;
  logic [31:0] rdata_next, rshift;
  logic [1:0]  off;
  logic [2:0]  nbytes;
  logic [3:0]  lane_mask;
  logic        req_fire, req_bad;

  assign req_ready = resetn && (state_reg == ST_IDLE);
  assign req_fire  = req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_reg;

  assign req_bad  = (req_size == 2'd3) ||
                    ((req_size == 2'd1) && req_addr[0]) ||
                    ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
  assign resp_err = err_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      err_reg <= 1'b0;
    else if (req_fire)
      err_reg <= req_bad;
  end
`else
  assign req_bad  = 1'b0;
  assign resp_err = 1'b0;
`endif

  // Alignment is forced down to the access size; legal requests are unaffected.
  always_comb begin
    off    = addr_reg[1:0];
    nbytes = 3'd4;
    case (size_reg)
      2'd0: begin
        off    = addr_reg[1:0];
        nbytes = 3'd1;
      end
      2'd1: begin
        off    = {addr_reg[1], 1'b0};
        nbytes = 3'd2;
      end
      default: begin
        off    = 2'b00;
        nbytes = 3'd4;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_mask[gi] = (3'(gi) >= {1'b0, off}) && (3'(gi) < ({1'b0, off} + nbytes));
    end
  endgenerate

  assign rshift = mem_rdata >> {off, 3'b000};

  always_comb begin
    rdata_next = rshift;
    case (size_reg)
      2'd0:    rdata_next = unsigned_reg ? {24'h0, rshift[7:0]}  : {{24{rshift[7]}}, rshift[7:0]};
      2'd1:    rdata_next = unsigned_reg ? {16'h0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
      default: rdata_next = rshift;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (req_fire) state_next = req_bad ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_next = ST_RESP;
      ST_RESP:  if (resp_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= ST_IDLE;
      wen_reg      <= 1'b0;
      unsigned_reg <= 1'b0;
      addr_reg     <= 32'h0;
      size_reg     <= 2'd0;
      wdata_reg    <= 32'h0;
      rdata_reg    <= 32'h0;
    end else begin
      state_reg <= state_next;
      if (req_fire) begin
        wen_reg      <= req_wen;
        unsigned_reg <= req_unsigned;
        addr_reg     <= req_addr;
        size_reg     <= req_size;
        wdata_reg    <= req_wdata;
        rdata_reg    <= 32'h0;
      end
      // Stores report zero data; loads capture the word seen during the access cycle.
      if (state_reg == ST_ISSUE)
        rdata_reg <= wen_reg ? 32'h0 : rdata_next;
    end
  end

  assign mem_valid  = (state_reg == ST_ISSUE);
  assign mem_wen    = mem_valid && wen_reg;
  assign mem_wmask  = mem_valid ? {4'b0000, lane_mask} : 8'h00;
  assign mem_raddr  = {addr_reg[31:2], 2'b00};
  assign mem_waddr  = {addr_reg[31:2], 2'b00};
  assign mem_wdata  = wdata_reg << {off, 3'b000};
  assign resp_valid = (state_reg == ST_RESP);
  assign resp_rdata = rdata_reg;

endmodule

// File: tb/tb_mem_lsu.sv
// Testbench for mem_lsu: directed scenarios plus randomized traffic against a byte-level memory model.
// Honours LSU_MISALIGN_TRAP_EN the same way as the design build.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_valid, mem_wen;
  logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_raddr(mem_raddr), .mem_wen(mem_wen),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata)
  );

  // RAM seen by the DUT (16 words at 0x8000_0000) and the reference copy kept by the model.
  logic [31:0] pmem [0:15] = '{default: 32'h0};
  logic [31:0] ref_mem [0:15] = '{default: 32'h0};
  logic [31:0] pm_word;
  int pmem_writes = 0;

  assign mem_rdata = pmem[mem_raddr[5:2]];

  always @(posedge clk) begin
    if (mem_valid && mem_wen) begin
      pm_word = pmem[mem_waddr[5:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) pm_word[8*b +: 8] = mem_wdata[8*b +: 8];
      pmem[mem_waddr[5:2]] <= pm_word;
      pmem_writes <= pmem_writes + 1;
    end
  end

  // Reference behaviour from the access rules, byte by byte.
  task automatic model(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata,
                       output logic e_err, output logic e_acc, output logic [31:0] e_addr,
                       output logic [7:0] e_mask, output logic [31:0] e_wdata,
                       output logic [31:0] e_rdata);
    int off, nb, idx;
    longint v, lm;
    off = int'(addr[1:0]);
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    idx = int'(addr[5:2]);
    e_err = 1'b0; e_acc = 1'b0; e_addr = 32'h0; e_mask = 8'h0; e_wdata = 32'h0; e_rdata = 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (size == 2'd3 || (off % nb) != 0) begin
      e_err = 1'b1;
      return;
    end
`else
    off = off - (off % nb);
`endif
    e_acc = 1'b1;
    e_addr = addr & ~32'h3;
    e_mask = 8'(((1 << nb) - 1) << off);
    e_wdata = wdata << (8 * off);
    if (wen) begin
      for (int b = 0; b < 4; b++)
        if (e_mask[b]) ref_mem[idx][8*b +: 8] = e_wdata[8*b +: 8];
    end else begin
      v = longint'(ref_mem[idx]) >> (8 * off);
      lm = (longint'(1) << (8 * nb)) - 1;
      v = v & lm;
      if (!uns && nb < 4 && v[8*nb-1]) v = v | ~lm;
      e_rdata = v[31:0];
    end
  endtask

  // Captures from the most recent transaction.
  logic        c_rdy, c_issue, c_mwen, c_err, c_timeout, c_mv_any;
  logic [31:0] c_waddr, c_raddr, c_wdata, c_rdata;
  logic [7:0]  c_mask;
  int          c_lat;

  task automatic txn(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                     input logic uns, input logic [31:0] wdata);
    int n;
    @(negedge clk);
    c_rdy = req_ready;
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0; req_wdata = $urandom;
    c_issue = mem_valid; c_mwen = mem_wen; c_waddr = mem_waddr; c_raddr = mem_raddr;
    c_mask = mem_wmask; c_wdata = mem_wdata; c_mv_any = mem_valid;
    c_lat = 1; n = 0;
    while (!resp_valid && n < 8) begin
      @(negedge clk);
      c_mv_any = c_mv_any | mem_valid;
      n++; c_lat++;
    end
    c_timeout = !resp_valid; c_rdata = resp_rdata; c_err = resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    $display("txn wen=%0b addr=%h size=%0d uns=%0b wdata=%h -> rdata=%h err=%0b lat=%0d",
             wen, addr, size, uns, wdata, c_rdata, c_err, c_lat);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    checks++; if (mem_valid !== 1'b0 || mem_wen !== 1'b0 || mem_wmask !== 8'h0) begin
      fails++; $display("FAIL rst_mem: valid=%b wen=%b mask=%h want 0", mem_valid, mem_wen, mem_wmask); end
    checks++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      fails++; $display("FAIL rst_resp: rdata=%h err=%b want 0", resp_rdata, resp_err); end
    resetn = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_store();
    logic e0, e1; logic [31:0] d0, d1, d2; logic [7:0] d3;
    model(1'b1, 32'h8000_0004, 2'd2, 1'b0, 32'hDEAD_BEEF, e0, e1, d0, d3, d1, d2);
    txn(1'b1, 32'h8000_0004, 2'd2, 1'b0, 32'hDEAD_BEEF);
    checks++; if (c_issue !== 1'b1 || c_mwen !== 1'b1) begin fails++; $display("FAIL st_word_issue: valid=%b wen=%b want 1 1", c_issue, c_mwen); end
    checks++; if (c_waddr !== 32'h8000_0004) begin fails++; $display("FAIL st_word_addr: got %h want 80000004", c_waddr); end
    checks++; if (c_mask !== 8'h0F) begin fails++; $display("FAIL st_word_mask: got %h want 0f", c_mask); end
    checks++; if (c_wdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL st_word_data: got %h want deadbeef", c_wdata); end
    checks++; if (c_lat !== 2 || c_rdata !== 32'h0 || c_err !== 1'b0) begin
      fails++; $display("FAIL st_word_resp: lat=%0d rdata=%h err=%b want 2 0 0", c_lat, c_rdata, c_err); end
    model(1'b1, 32'h8000_0003, 2'd0, 1'b0, 32'h0000_00AB, e0, e1, d0, d3, d1, d2);
    txn(1'b1, 32'h8000_0003, 2'd0, 1'b0, 32'h0000_00AB);
    checks++; if (c_mask !== 8'h08 || c_wdata !== 32'hAB00_0000) begin
      fails++; $display("FAIL st_byte: mask=%h data=%h want 08 ab000000", c_mask, c_wdata); end
    model(1'b1, 32'h8000_0002, 2'd1, 1'b0, 32'h0000_1234, e0, e1, d0, d3, d1, d2);
    txn(1'b1, 32'h8000_0002, 2'd1, 1'b0, 32'h0000_1234);
    checks++; if (c_mask !== 8'h0C || c_wdata !== 32'h1234_0000) begin
      fails++; $display("FAIL st_half: mask=%h data=%h want 0c 12340000", c_mask, c_wdata); end
  endtask

  task automatic test_load();
    logic [31:0] la [4] = '{32'h8000_0011, 32'h8000_0012, 32'h8000_0013, 32'h8000_0012};
    logic [1:0]  ls [4] = '{2'd0, 2'd0, 2'd0, 2'd1};
    logic        lu [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] lx [4] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF};
    logic e0, e1; logic [31:0] d0, d1, d2; logic [7:0] d3;
    model(1'b1, 32'h8000_0010, 2'd2, 1'b0, 32'h80FF_7F01, e0, e1, d0, d3, d1, d2);
    txn(1'b1, 32'h8000_0010, 2'd2, 1'b0, 32'h80FF_7F01);
    for (int k = 0; k < 4; k++) begin
      txn(1'b0, la[k], ls[k], lu[k], 32'h0);
      checks++; if (c_rdata !== lx[k] || c_err !== 1'b0 || c_raddr !== 32'h8000_0010) begin
        fails++; $display("FAIL ld_ext_%0d: rdata=%h err=%b raddr=%h want %h 0 80000010", k, c_rdata, c_err, c_raddr, lx[k]); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0011; req_size = 2'd0; req_unsigned = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_007F || req_ready !== 1'b0) begin
        fails++; $display("FAIL bp_hold_%0d: valid=%b rdata=%h ready=%b want 1 0000007f 0", k, resp_valid, resp_rdata, req_ready); end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      fails++; $display("FAIL bp_release: ready=%b valid=%b want 1 0", req_ready, resp_valid); end
    req_valid = 1'b1; req_addr = 32'h8000_0010; req_size = 2'd2;
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (mem_valid !== 1'b1) begin fails++; $display("FAIL b2b_issue: mem_valid=%b want 1", mem_valid); end
    resp_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 8);
    checks++; if (resp_valid !== 1'b1 || n !== 1 || resp_rdata !== 32'h80FF_7F01) begin
      fails++; $display("FAIL b2b_resp: valid=%b wait=%0d rdata=%h want 1 1 80ff7f01", resp_valid, n, resp_rdata); end
    @(negedge clk);
    resp_ready = 1'b0;
    $display("txn back_to_back done");
  endtask

  task automatic test_misaligned();
    txn(1'b0, 32'h8000_0002, 2'd2, 1'b0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (c_err !== 1'b1 || c_lat !== 1 || c_mv_any !== 1'b0 || c_rdata !== 32'h0) begin
      fails++; $display("FAIL mis_word_trap: err=%b lat=%0d mv=%b rdata=%h want 1 1 0 0", c_err, c_lat, c_mv_any, c_rdata); end
`else
    checks++; if (c_err !== 1'b0 || c_issue !== 1'b1 || c_raddr !== 32'h8000_0000 || c_rdata !== ref_mem[0]) begin
      fails++; $display("FAIL mis_word_force: err=%b valid=%b raddr=%h rdata=%h want 0 1 80000000 %h", c_err, c_issue, c_raddr, c_rdata, ref_mem[0]); end
`endif
    txn(1'b0, 32'h8000_0000, 2'd3, 1'b0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (c_err !== 1'b1 || c_mv_any !== 1'b0) begin
      fails++; $display("FAIL size3_trap: err=%b mv=%b want 1 0", c_err, c_mv_any); end
`else
    checks++; if (c_err !== 1'b0 || c_rdata !== ref_mem[0]) begin
      fails++; $display("FAIL size3_word: err=%b rdata=%h want 0 %h", c_err, c_rdata, ref_mem[0]); end
`endif
  endtask

  task automatic test_reset_mid_issue();
    int pw;
    pw = pmem_writes;
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0008; req_size = 2'd2; req_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (mem_valid !== 1'b1) begin fails++; $display("FAIL rmi_in_issue: mem_valid=%b want 1", mem_valid); end
    #1 resetn = 1'b0;
    #1;
    checks++; if (mem_valid !== 1'b0 || mem_wen !== 1'b0) begin
      fails++; $display("FAIL rmi_async_drop: valid=%b wen=%b want 0 0", mem_valid, mem_wen); end
    @(posedge clk); #1;
    checks++; if (pmem_writes !== pw || pmem[2] !== ref_mem[2]) begin
      fails++; $display("FAIL rmi_no_write: writes=%0d word=%h want %0d %h", pmem_writes, pmem[2], pw, ref_mem[2]); end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      fails++; $display("FAIL rmi_release: ready=%b valid=%b want 1 0", req_ready, resp_valid); end
    $display("txn reset_mid_issue done");
  endtask

  task automatic test_random();
    logic wen, uns, e_err, e_acc;
    logic [1:0] size;
    logic [31:0] addr, wdata, e_addr, e_wdata, e_rdata;
    logic [7:0] e_mask;
    for (int i = 0; i < 16; i++) begin
      wdata = $urandom;
      model(1'b1, 32'h8000_0000 + 32'(i * 4), 2'd2, 1'b0, wdata, e_err, e_acc, e_addr, e_mask, e_wdata, e_rdata);
      txn(1'b1, 32'h8000_0000 + 32'(i * 4), 2'd2, 1'b0, wdata);
    end
    for (int i = 0; i < 150; i++) begin
      wen = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3)); wdata = $urandom;
      addr = 32'h8000_0000 | 32'($urandom_range(0, 63));
      model(wen, addr, size, uns, wdata, e_err, e_acc, e_addr, e_mask, e_wdata, e_rdata);
      txn(wen, addr, size, uns, wdata);
      checks++; if (c_timeout !== 1'b0 || c_rdy !== 1'b1) begin fails++; $display("FAIL rnd_hs_%0d: timeout=%b ready=%b want 0 1", i, c_timeout, c_rdy); end
      checks++; if (c_err !== e_err) begin fails++; $display("FAIL rnd_err_%0d: got %b want %b", i, c_err, e_err); end
      checks++; if (c_rdata !== e_rdata) begin fails++; $display("FAIL rnd_rdata_%0d: got %h want %h", i, c_rdata, e_rdata); end
      checks++; if (c_lat !== (e_err ? 1 : 2) || c_mv_any !== e_acc) begin
        fails++; $display("FAIL rnd_timing_%0d: lat=%0d access=%b want %0d %b", i, c_lat, c_mv_any, e_err ? 1 : 2, e_acc); end
      if (e_acc) begin
        checks++; if (c_raddr !== e_addr || c_waddr !== e_addr || c_mwen !== wen) begin
          fails++; $display("FAIL rnd_addr_%0d: raddr=%h waddr=%h wen=%b want %h %b", i, c_raddr, c_waddr, c_mwen, e_addr, wen); end
        checks++; if (c_mask !== (wen ? e_mask : 8'h00) && wen) begin
          fails++; $display("FAIL rnd_mask_%0d: got %h want %h", i, c_mask, e_mask); end
        if (wen) begin
          checks++; if (c_wdata !== e_wdata) begin fails++; $display("FAIL rnd_wdata_%0d: got %h want %h", i, c_wdata, e_wdata); end
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      checks++; if (pmem[i] !== ref_mem[i]) begin fails++; $display("FAIL rnd_mem_%0d: got %h want %h", i, pmem[i], ref_mem[i]); end
    end
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_size = 2'd0;
    req_unsigned = 1'b0; req_wdata = 32'h0; resp_ready = 1'b0;
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_misaligned();
    test_reset_mid_issue();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
